// File: rtl/hashmap_pkg.sv
// Shared constants for the hash-table lookup path and its table writer.
// Default widths and the CRC-32 polynomial live here so both sides agree on the bucket layout.
package hashmap_pkg;

    localparam logic [31:0] CRC32_POLY          = 32'h04c11db7;
    localparam int          DEFAULT_KEY_WIDTH   = 32;
    localparam int          DEFAULT_VALUE_WIDTH = 32;
    localparam int          DEFAULT_ADDR_WIDTH  = 10;
    localparam int          DEFAULT_FIFO_DEPTH  = 4;

    // Bucket word is {valid, key, value}, valid in the MSB.
    function automatic int entry_width(input int key_w, input int value_w);
        return 1 + key_w + value_w;
    endfunction

endpackage

// File: rtl/crc.sv
// Combinational CRC: zero initial value, data consumed MSB first, no reflection, no final XOR.
// The result equals (data * x^POLY_SIZE) mod P, so single-bit keys map straight onto POLY.
module crc
    import hashmap_pkg::*;
#(
    parameter int                    POLY_SIZE  = 32,
    parameter logic [POLY_SIZE-1:0]  POLY       = CRC32_POLY,
    parameter int                    DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [POLY_SIZE-1:0]  crc_out
);

    function automatic logic [POLY_SIZE-1:0] crc_calc(input logic [DATA_WIDTH-1:0] d);
        logic [POLY_SIZE-1:0] r;
        logic                 fb;
        r = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            fb = r[POLY_SIZE-1] ^ d[i];
            r  = r << 1;
            if (fb) begin
                r = r ^ POLY;
            end
        end
        return r;
    endfunction

    assign crc_out = crc_calc(data_in);

endmodule

// File: rtl/hash_lookup_fifo.sv
// Synchronous result FIFO with a registered show-ahead head, occupancy count and async reset.
// The head register holds the last popped word once the FIFO drains.
module hash_lookup_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_next;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_next = rd_ptr + 1'b1;

    // NOTE: the storage array has no reset; only pointers, count and the head register do.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end

            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            // Head follows the next valid entry; a push into an (about to be) empty FIFO bypasses storage.
            if (do_push && (empty || (do_pop && count == CNT_ONE))) begin
                rd_data <= wr_data;
            end else if (do_pop && count > CNT_ONE) begin
                rd_data <= mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/hash_lookup.sv
// Pipelined hash-table lookup: CRC the key, read one bucket from a 1-cycle sync RAM, compare,
// and queue {hit, value, key, hash} in a result FIFO guarded by a credit counter.
module hash_lookup
    import hashmap_pkg::*;
#(
    parameter int          KEY_WIDTH   = DEFAULT_KEY_WIDTH,
    parameter int          VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
    parameter int          ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter logic [31:0] POLY        = CRC32_POLY,
    parameter int          FIFO_DEPTH  = DEFAULT_FIFO_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [KEY_WIDTH-1:0]                 in_key,
    output logic                                 mem_rd_en,
    output logic [ADDR_WIDTH-1:0]                mem_rd_addr,
    input  logic [1+KEY_WIDTH+VALUE_WIDTH-1:0]   mem_rd_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 out_hit,
    output logic [VALUE_WIDTH-1:0]               out_value,
    output logic [KEY_WIDTH-1:0]                 out_key,
    output logic [ADDR_WIDTH-1:0]                out_hash
);

    localparam int EW = entry_width(KEY_WIDTH, VALUE_WIDTH);
    localparam int DW = 1 + VALUE_WIDTH + KEY_WIDTH + ADDR_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CW-1:0] CREDIT_ONE = CW'(1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);

    logic [31:0]            crc_value;
    logic [ADDR_WIDTH-1:0]  hash;
    logic                   accept;
    logic                   pop;
    logic [CW-1:0]          credits;
    logic [CW-1:0]          credits_next;

    // Stage A registers double as the table read request.
    logic                   a_valid;
    logic [KEY_WIDTH-1:0]   a_key;
    logic [ADDR_WIDTH-1:0]  a_hash;

    // Stage B carries the request alongside the outstanding RAM read.
    logic                   b_valid;
    logic [KEY_WIDTH-1:0]   b_key;
    logic [ADDR_WIDTH-1:0]  b_hash;

    logic                   entry_valid;
    logic [KEY_WIDTH-1:0]   entry_key;
    logic [VALUE_WIDTH-1:0] entry_value;
    logic                   c_hit;
    logic [VALUE_WIDTH-1:0] c_value;

    logic [DW-1:0]          fifo_wr_data;
    logic [DW-1:0]          fifo_rd_data;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [CW-1:0]          fifo_count;
    logic                   unused_bits;

    crc #(
        .POLY_SIZE  (32),
        .POLY       (POLY),
        .DATA_WIDTH (KEY_WIDTH)
    ) u_crc (
        .data_in (in_key),
        .crc_out (crc_value)
    );

    assign hash   = crc_value[ADDR_WIDTH-1:0];
    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    always_comb begin
        credits_next = credits;
        case ({accept, pop})
            2'b10:   credits_next = credits + CREDIT_ONE;
            2'b01:   credits_next = credits - CREDIT_ONE;
            default: credits_next = credits;
        endcase
    end

    // NOTE: in_ready is registered from credits_next, so it already reflects this cycle's accept/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits  <= '0;
            in_ready <= 1'b0;
        end else begin
            credits  <= credits_next;
            in_ready <= (credits_next < CREDIT_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_key   <= '0;
            a_hash  <= '0;
            b_valid <= 1'b0;
            b_key   <= '0;
            b_hash  <= '0;
        end else begin
            a_valid <= accept;
            if (accept) begin
                a_key  <= in_key;
                a_hash <= hash;
            end
            b_valid <= a_valid;
            if (a_valid) begin
                b_key  <= a_key;
                b_hash <= a_hash;
            end
        end
    end

    assign mem_rd_en   = a_valid;
    assign mem_rd_addr = a_hash;

    assign entry_valid = mem_rd_data[EW-1];
    assign entry_key   = mem_rd_data[EW-2 -: KEY_WIDTH];
    assign entry_value = mem_rd_data[VALUE_WIDTH-1:0];

    assign c_hit        = entry_valid && (entry_key == b_key);
    assign c_value      = c_hit ? entry_value : '0;
    assign fifo_wr_data = {c_hit, c_value, b_key, b_hash};

    hash_lookup_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (b_valid),
        .wr_data (fifo_wr_data),
        .pop     (out_ready),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign {out_hit, out_value, out_key, out_hash} = fifo_rd_data;

    assign unused_bits = ^{crc_value, fifo_count, fifo_full};

endmodule

// File: tb/tb_hash_lookup.sv
// Self-checking bench for hash_lookup: directed latency/boundary cases plus a random key stream
// scored against a polynomial-division lookup model and a 1-cycle synchronous table RAM.
module tb_hash_lookup;
    import hashmap_pkg::*;

    localparam int KW = 32;
    localparam int VW = 32;
    localparam int AW = 10;
    localparam int FD = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [KW-1:0] in_key;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [64:0]   mem_rd_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_hit;
    logic [VW-1:0] out_value;
    logic [KW-1:0] out_key;
    logic [AW-1:0] out_hash;

    hash_lookup #(
        .KEY_WIDTH   (KW),
        .VALUE_WIDTH (VW),
        .ADDR_WIDTH  (AW),
        .POLY        (CRC32_POLY),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_key      (in_key),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_hit     (out_hit),
        .out_value   (out_value),
        .out_key     (out_key),
        .out_hash    (out_hash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table RAM: {valid, key, value}, data returned the cycle after the read strobe.
    logic [64:0] tbl [1 << AW];
    initial mem_rd_data = '0;
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= tbl[mem_rd_addr];
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // CRC as polynomial remainder of key * x^32 modulo the 33-bit generator.
    function automatic logic [31:0] model_crc(input logic [31:0] k);
        logic [63:0] r;
        logic [63:0] g;
        r = {k, 32'h0};
        g = {31'b0, 1'b1, CRC32_POLY};
        for (int b = 63; b >= 32; b--) begin
            if (r[b]) r = r ^ (g << (b - 32));
        end
        return r[31:0];
    endfunction

    function automatic logic [AW-1:0] model_hash(input logic [31:0] k);
        logic [31:0] c;
        c = model_crc(k);
        return c[AW-1:0];
    endfunction

    typedef struct {
        logic          hit;
        logic [VW-1:0] value;
        logic [KW-1:0] key;
        logic [AW-1:0] hash;
    } res_t;

    res_t exp_q[$];

    function automatic res_t model_lookup(input logic [KW-1:0] k);
        res_t        r;
        logic [64:0] e;
        r.key   = k;
        r.hash  = model_hash(k);
        e       = tbl[r.hash];
        r.hit   = e[64] && (e[63:32] == k);
        r.value = r.hit ? e[31:0] : '0;
        return r;
    endfunction

    // Scoreboard: inputs change just after posedge, so negedge sees what the next edge will act on.
    always @(negedge clk) begin
        res_t r;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (in_valid && in_ready) exp_q.push_back(model_lookup(in_key));
            if (out_valid && out_ready) begin
                check("sb_result_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    r = exp_q.pop_front();
                    check("sb_hit",   out_hit,   r.hit);
                    check("sb_value", out_value, r.value);
                    check("sb_key",   out_key,   r.key);
                    check("sb_hash",  out_hash,  r.hash);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (out_valid && n < 40) begin
            tick();
            n++;
        end
        check(tag, out_valid, 1'b0);
    endtask

    logic [KW-1:0] keys [100];
    int            acc;
    int            cycles;
    int            idx;
    int            stale;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_key    = '0;
        out_ready = 1'b0;
        for (int i = 0; i < (1 << AW); i++) tbl[i] = '0;

        #12;
        check("rst_in_ready",  in_ready,    1'b0);
        check("rst_mem_rd_en", mem_rd_en,   1'b0);
        check("rst_mem_addr",  mem_rd_addr, '0);
        check("rst_out_valid", out_valid,   1'b0);
        check("rst_out_hit",   out_hit,     1'b0);
        check("rst_out_value", out_value,   '0);
        check("rst_out_key",   out_key,     '0);
        check("rst_out_hash",  out_hash,    '0);

        tick();
        rst_n = 1'b1;
        check("rel_in_ready_before_edge", in_ready, 1'b0);
        tick();
        check("rel_in_ready_after_edge", in_ready, 1'b1);

        // Key 1 on an empty table: miss, bucket 0x1b7, latency 3.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_key    = 32'h1;
        tick();
        in_valid = 1'b0;
        check("t1_rd_en",   mem_rd_en,   1'b1);
        check("t1_rd_addr", mem_rd_addr, 10'h1b7);
        check("t1_valid_t1", out_valid,  1'b0);
        tick();
        check("t1_valid_t2", out_valid,  1'b0);
        check("t1_rd_en_off", mem_rd_en, 1'b0);
        tick();
        check("t1_valid_t3", out_valid,  1'b1);
        check("t1_hit",      out_hit,    1'b0);
        check("t1_value",    out_value,  '0);
        check("t1_hash",     out_hash,   10'h1b7);
        tick();
        check("t1_popped",   out_valid,  1'b0);

        // Key 2 with a matching entry at bucket 0x36e: hit.
        tbl[10'h36e] = {1'b1, 32'h2, 32'hCAFE};
        in_valid = 1'b1;
        in_key   = 32'h2;
        tick();
        in_valid = 1'b0;
        check("t2_rd_addr", mem_rd_addr, 10'h36e);
        tick();
        tick();
        check("t2_valid", out_valid, 1'b1);
        check("t2_hit",   out_hit,   1'b1);
        check("t2_value", out_value, 32'hCAFE);
        check("t2_key",   out_key,   32'h2);
        tick();

        // Key 0 hashes to bucket 0 which holds a different key: miss.
        tbl[0] = {1'b1, 32'h5, 32'h1234};
        in_valid = 1'b1;
        in_key   = 32'h0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("t3_valid", out_valid, 1'b1);
        check("t3_hit",   out_hit,   1'b0);
        check("t3_value", out_value, '0);
        check("t3_hash",  out_hash,  '0);
        tick();

        // Back-pressure: credits admit exactly FIFO_DEPTH requests.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            in_key = $urandom;
            if (in_ready) acc++;
            tick();
        end
        check("t4_accepts",     acc,       FD);
        check("t4_ready_low",   in_ready,  1'b0);
        check("t4_full_valid",  out_valid, 1'b1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t4_ready_return", in_ready, 1'b1);
        drain("t4_drain");

        // Random stream with planted hits and key-mismatch entries.
        for (int i = 0; i < 100; i++) begin
            keys[i] = $urandom;
            if (i % 3 == 0)      tbl[model_hash(keys[i])] = {1'b1, keys[i], 32'($urandom)};
            else if (i % 3 == 1) tbl[model_hash(keys[i])] = {1'b1, 32'($urandom), 32'($urandom)};
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        idx    = 0;
        cycles = 0;
        while (idx < 100 && cycles < 1000) begin
            in_key = keys[idx];
            if (in_ready) idx++;
            cycles++;
            tick();
        end
        in_valid = 1'b0;
        check("t5_all_accepted", idx,    100);
        check("t5_one_per_cycle", cycles, 100);
        drain("t5_drain");

        // Reset with requests in flight discards everything.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_key = $urandom;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("t6_valid_before_rst", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_valid_in_rst",  out_valid, 1'b0);
        check("t6_ready_in_rst",  in_ready,  1'b0);
        check("t6_rd_en_in_rst",  mem_rd_en, 1'b0);
        tick();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) stale++;
        end
        check("t6_no_stale", stale, 0);
        check("t6_ready_after", in_ready, 1'b1);

        check("sb_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
